// File: rtl/tx_wr_arb_pkg.sv
// tx_wr_arb_pkg: shared types and constants for the TX FIFO write arbiter.
package tx_wr_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    ISSUE_HI = 2'd2
  } arb_state_e;

  // Requester indices, also used as bit positions in pend/ovf vectors.
  localparam int         NUM_REQ = 3;
  localparam logic [1:0] REQ_RF  = 2'd0;
  localparam logic [1:0] REQ_ALU = 2'd1;
  localparam logic [1:0] REQ_ERR = 2'd2;

  // Round-robin successor of idx among n_active requesters (wraps to 0).
  function automatic logic [1:0] rr_next(input logic [1:0] idx, input logic [1:0] n_active);
    return (idx == n_active - 2'd1) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/tx_wr_arb_req_hold.sv
// tx_req_hold: one-entry holding register for a single-cycle-pulse producer.
// A pulse is captured when the entry is free or is being released in the
// same cycle; otherwise the pulse is dropped and reported on drop.
module tx_req_hold #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld,
  input  logic [W-1:0] data,
  input  logic         rel,
  output logic         pend,
  output logic [W-1:0] held,
  output logic         drop
);

  logic         pend_q, pend_d;
  logic [W-1:0] data_q, data_d;

  // Capture / drop / release rules for the single entry.
  always_comb begin
    pend_d = pend_q;
    data_d = data_q;
    drop   = 1'b0;
    if (rel) begin
      pend_d = 1'b0;
    end
    if (vld) begin
      if (!pend_q || rel) begin
        data_d = data;
        pend_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
  end

  // Entry state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= 1'b0;
      data_q <= '0;
    end else begin
      pend_q <= pend_d;
      data_q <= data_d;
    end
  end

  assign pend = pend_q;
  assign held = data_q;

endmodule

// File: rtl/tx_wr_arb.sv
// tx_wr_arb: round-robin arbiter feeding the TX async-FIFO write port from
// RF bytes, 16-bit ALU words (sent LSB then MSB, atomically) and an optional
// ERR status byte.
// Build option: define TX_WR_ARB_ERR_EN to enable the ERR requester; when
// undefined, err_vld/err_code are ignored and the pointer rotates over RF/ALU.
//
// Handshake: producers issue one-cycle vld pulses with no back-pressure
// (a pulse that finds its entry busy is dropped and flagged in ovf); the
// FIFO side is write-when-not-full: wr_inc = in-issue && !fifo_full, and
// wr_data is held stable while fifo_full stalls the transfer.
module tx_wr_arb
  import tx_wr_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rf_vld,
  input  logic [DATA_WIDTH-1:0]   rf_data,
  input  logic                    alu_vld,
  input  logic [2*DATA_WIDTH-1:0] alu_data,
  input  logic                    err_vld,
  input  logic [DATA_WIDTH-1:0]   err_code,
  input  logic                    fifo_full,
  input  logic                    ovf_clr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    wr_inc,
  output logic [2:0]              ovf,
  output logic                    idle
);

  logic [NUM_REQ-1:0]      pend;
  logic [NUM_REQ-1:0]      drop;
  logic [NUM_REQ-1:0]      rel;
  logic [DATA_WIDTH-1:0]   rf_held;
  logic [DATA_WIDTH-1:0]   err_held;
  logic [2*DATA_WIDTH-1:0] alu_held;

  arb_state_e state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] rr_q, rr_d;
  logic [2:0] ovf_q, ovf_d;

  logic       sel_vld;
  logic [1:0] sel_idx;
  logic [1:0] cand;

  tx_req_hold #(.W(DATA_WIDTH)) u_rf (
    .clk (clk), .rst (rst), .vld (rf_vld), .data (rf_data), .rel (rel[REQ_RF]),
    .pend (pend[REQ_RF]), .held (rf_held), .drop (drop[REQ_RF])
  );

  tx_req_hold #(.W(2*DATA_WIDTH)) u_alu (
    .clk (clk), .rst (rst), .vld (alu_vld), .data (alu_data), .rel (rel[REQ_ALU]),
    .pend (pend[REQ_ALU]), .held (alu_held), .drop (drop[REQ_ALU])
  );

`ifdef TX_WR_ARB_ERR_EN
  localparam logic [1:0] N_ACTIVE = 2'd3;

  tx_req_hold #(.W(DATA_WIDTH)) u_err (
    .clk (clk), .rst (rst), .vld (err_vld), .data (err_code), .rel (rel[REQ_ERR]),
    .pend (pend[REQ_ERR]), .held (err_held), .drop (drop[REQ_ERR])
  );
`else
  localparam logic [1:0] N_ACTIVE = 2'd2;

  // ERR requester absent: its inputs are deliberately left unconnected.
  logic unused_err;
  assign unused_err     = ^{err_vld, err_code, rel[REQ_ERR]};
  assign pend[REQ_ERR]  = 1'b0;
  assign drop[REQ_ERR]  = 1'b0;
  assign err_held       = '0;
`endif

  // Round-robin search: the pending requester closest to rr_q (inclusive) wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = rr_q;
    cand    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = 2'((int'(rr_q) + i) % NUM_REQ);
      if (pend[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

  // FSM next state, grant/pointer update, release strobes and write decode.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    rel     = '0;
    wr_inc  = 1'b0;
    wr_data = '0;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          grant_d = sel_idx;
          rr_d    = rr_next(sel_idx, N_ACTIVE);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        case (grant_q)
          REQ_ALU: wr_data = alu_held[DATA_WIDTH-1:0];
          REQ_ERR: wr_data = err_held;
          default: wr_data = rf_held;
        endcase
        wr_inc = !fifo_full;
        if (!fifo_full) begin
          if (grant_q == REQ_ALU) begin
            state_d = ISSUE_HI;
          end else begin
            rel[grant_q] = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      ISSUE_HI: begin
        wr_data = alu_held[2*DATA_WIDTH-1:DATA_WIDTH];
        wr_inc  = !fifo_full;
        if (!fifo_full) begin
          rel[REQ_ALU] = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sticky overflow flags: a new drop beats a simultaneous clear.
  always_comb begin
    ovf_d = (ovf_clr ? 3'b000 : ovf_q) | drop;
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= REQ_RF;
      rr_q    <= REQ_RF;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf  = ovf_q;
  assign idle = (state_q == IDLE) && (pend == '0);

endmodule

// File: tb/tb_tx_wr_arb.sv
// tb_tx_wr_arb: table vectors, directed corner sequences and random traffic
// for tx_wr_arb, checked against a transaction-level reference model.
module tb_tx_wr_arb;

`ifdef TX_WR_ARB_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk, rst;
  logic        rf_vld, alu_vld, err_vld, fifo_full, ovf_clr;
  logic [7:0]  rf_data, err_code;
  logic [15:0] alu_data;
  logic [7:0]  wr_data;
  logic        wr_inc, idle;
  logic [2:0]  ovf;

  tx_wr_arb #(.DATA_WIDTH(8)) dut (
    .clk (clk), .rst (rst),
    .rf_vld (rf_vld), .rf_data (rf_data),
    .alu_vld (alu_vld), .alu_data (alu_data),
    .err_vld (err_vld), .err_code (err_code),
    .fifo_full (fifo_full), .ovf_clr (ovf_clr),
    .wr_data (wr_data), .wr_inc (wr_inc), .ovf (ovf), .idle (idle)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Each requester: pending flag + held word. The transfer in progress is a
  // queue of bytes still to be written; an empty queue means the arbiter is
  // between grants.
  bit          m_pend[3];
  logic [15:0] m_held[3];
  logic [7:0]  m_bytes[$];
  int          m_owner;
  int          m_ptr;
  logic [2:0]  m_ovf;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = 1'b0;
      m_held[i] = '0;
    end
    m_bytes.delete();
    m_owner = 0;
    m_ptr   = 0;
    m_ovf   = '0;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit rv, input logic [7:0] rd, input bit av, input logic [15:0] ad,
                      input bit ev, input logic [7:0] ed, input bit full, input bit clr);
    bit          busy;
    int          n;
    logic [2:0]  rel;
    logic [2:0]  dropped;
    bit          v[3];
    logic [15:0] d[3];
    @(negedge clk);
    rf_vld = rv; rf_data = rd; alu_vld = av; alu_data = ad;
    err_vld = ev; err_code = ed; fifo_full = full; ovf_clr = clr;
    #1;
    busy = (m_bytes.size() > 0);
    check("wr_inc", wr_inc, busy && !full);
    if (busy) check("wr_data", wr_data, m_bytes[0]);
    check("ovf", ovf, m_ovf);
    check("idle", idle, !busy && !(m_pend[0] || m_pend[1] || m_pend[2]));
    if (wr_inc) got_q.push_back(wr_data);
    // advance the model by one clock
    n   = ERR_EN ? 3 : 2;
    rel = '0;
    if (busy) begin
      if (!full) begin
        void'(m_bytes.pop_front());
        if (m_bytes.size() == 0) rel[m_owner] = 1'b1;
      end
    end else begin
      for (int k = 0; k < n; k++) begin
        int idx;
        idx = (m_ptr + k) % n;
        if (m_pend[idx]) begin
          m_owner = idx;
          m_bytes.push_back(m_held[idx][7:0]);
          if (idx == 1) m_bytes.push_back(m_held[idx][15:8]);
          m_ptr = (idx + 1) % n;
          break;
        end
      end
    end
    v[0] = rv; v[1] = av; v[2] = ev && ERR_EN;
    d[0] = {8'h00, rd}; d[1] = ad; d[2] = {8'h00, ed};
    dropped = '0;
    for (int i = 0; i < 3; i++) begin
      if (v[i]) begin
        if (!m_pend[i] || rel[i]) begin
          m_held[i] = d[i];
          m_pend[i] = 1'b1;
        end else begin
          dropped[i] = 1'b1;
        end
      end else if (rel[i]) begin
        m_pend[i] = 1'b0;
      end
    end
    m_ovf = (clr ? 3'b000 : m_ovf) | dropped;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) step(0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    rf_vld = 0; alu_vld = 0; err_vld = 0; fifo_full = 0; ovf_clr = 0;
    #1;
    check("rst_wr_inc", wr_inc, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_ovf", ovf, 0);
    check("rst_idle", idle, 1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    bit          rv;
    logic [7:0]  rd;
    bit          av;
    logic [15:0] ad;
    bit          e_inc;
    logic [7:0]  e_data;
    bit          e_idle;
  } vec_t;

  vec_t vecs[16];

  // ---------------- test sequence ----------------
  initial begin
    int wr_cnt;
    rst = 1'b0;
    rf_vld = 0; rf_data = 0; alu_vld = 0; alu_data = 0;
    err_vld = 0; err_code = 0; fifo_full = 0; ovf_clr = 0;
    model_reset();
    do_reset();

    // single RF byte, single ALU word, then RF+ALU together (pointer favours RF)
    vecs[0]  = '{1, 8'h5A, 0, 16'h0000, 0, 8'h00, 1};
    vecs[1]  = '{0, 8'h00, 0, 16'h0000, 0, 8'h00, 0};
    vecs[2]  = '{0, 8'h00, 0, 16'h0000, 1, 8'h5A, 0};
    vecs[3]  = '{0, 8'h00, 0, 16'h0000, 0, 8'h00, 1};
    vecs[4]  = '{0, 8'h00, 1, 16'hBEEF, 0, 8'h00, 1};
    vecs[5]  = '{0, 8'h00, 0, 16'h0000, 0, 8'h00, 0};
    vecs[6]  = '{0, 8'h00, 0, 16'h0000, 1, 8'hEF, 0};
    vecs[7]  = '{0, 8'h00, 0, 16'h0000, 1, 8'hBE, 0};
    vecs[8]  = '{0, 8'h00, 0, 16'h0000, 0, 8'h00, 1};
    vecs[9]  = '{1, 8'h11, 1, 16'h2233, 0, 8'h00, 1};
    vecs[10] = '{0, 8'h00, 0, 16'h0000, 0, 8'h00, 0};
    vecs[11] = '{0, 8'h00, 0, 16'h0000, 1, 8'h11, 0};
    vecs[12] = '{0, 8'h00, 0, 16'h0000, 0, 8'h00, 0};
    vecs[13] = '{0, 8'h00, 0, 16'h0000, 1, 8'h33, 0};
    vecs[14] = '{0, 8'h00, 0, 16'h0000, 1, 8'h22, 0};
    vecs[15] = '{0, 8'h00, 0, 16'h0000, 0, 8'h00, 1};
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].rv, vecs[i].rd, vecs[i].av, vecs[i].ad, 0, 8'h00, 0, 0);
      check($sformatf("vec%0d_inc", i), wr_inc, vecs[i].e_inc);
      if (vecs[i].e_inc) check($sformatf("vec%0d_data", i), wr_data, vecs[i].e_data);
      check($sformatf("vec%0d_idle", i), idle, vecs[i].e_idle);
    end

    // RF alone moves the pointer to ALU, so the next RF+ALU pair sends ALU first
    got_q.delete();
    step(1, 8'h11, 0, 16'h0000, 0, 8'h00, 0, 0);
    idle_cycles(4);
    step(1, 8'h11, 1, 16'h2233, 0, 8'h00, 0, 0);
    idle_cycles(10);
    exp_q = '{8'h11, 8'h33, 8'h22, 8'h11};
    check("rr_seq_len", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("rr_seq_%0d", i), got_q[i], exp_q[i]);

    // FIFO full for 5 cycles while the ALU MSB is pending
    got_q.delete();
    step(0, 8'h00, 1, 16'hA1B2, 0, 8'h00, 0, 0);
    idle_cycles(2);
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, 0, 16'h0000, 0, 8'h00, 1, 0);
      check("stall_inc", wr_inc, 0);
      check("stall_data", wr_data, 8'hA1);
    end
    step(0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 0);
    check("stall_rel_inc", wr_inc, 1);
    check("stall_rel_data", wr_data, 8'hA1);
    idle_cycles(2);
    exp_q = '{8'hB2, 8'hA1};
    check("stall_len", got_q.size(), 2);
    for (int i = 0; i < 2 && i < got_q.size(); i++)
      check($sformatf("stall_seq_%0d", i), got_q[i], exp_q[i]);

    // second RF pulse while the first is held back by a full FIFO is dropped
    got_q.delete();
    step(1, 8'h01, 0, 16'h0000, 0, 8'h00, 1, 0);
    step(1, 8'h02, 0, 16'h0000, 0, 8'h00, 1, 0);
    repeat (4) step(0, 8'h00, 0, 16'h0000, 0, 8'h00, 1, 0);
    idle_cycles(4);
    check("drop_len", got_q.size(), 1);
    if (got_q.size() > 0) check("drop_byte", got_q[0], 8'h01);
    check("drop_ovf0", ovf[0], 1);
    step(0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 0);
    check("ovf_clr", ovf[0], 0);

    // reset while stalled in the MSB phase: MSB never appears afterwards
    step(0, 8'h00, 1, 16'h1234, 0, 8'h00, 0, 0);
    idle_cycles(2);
    step(0, 8'h00, 0, 16'h0000, 0, 8'h00, 1, 0);
    do_reset();
    got_q.delete();
    idle_cycles(6);
    check("rst_no_msb", got_q.size(), 0);

    // ERR pulse only produces a write when the ERR requester is built in
    got_q.delete();
    step(0, 8'h00, 0, 16'h0000, 1, 8'h77, 0, 0);
    idle_cycles(5);
    wr_cnt = got_q.size();
    check("err_writes", wr_cnt, ERR_EN ? 1 : 0);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      step($urandom_range(0, 3) == 0, 8'($urandom),
           $urandom_range(0, 3) == 0, 16'($urandom),
           $urandom_range(0, 3) == 0, 8'($urandom),
           $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
